// File: rtl/layer2_bin_writer_pkg.sv
// layer2_bin_writer_pkg: shared sizing constants and writer state encoding
package layer2_bin_writer_pkg;
  localparam int DEPTH = 512;
  localparam int ADDR_W = 9;
  localparam int ACC_W = 16;
  localparam logic signed [ACC_W-1:0] THRESH = '0;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/layer2_bin_writer_binarize.sv
// layer2_binarize: signed threshold compare, 1 when data >= thresh
module layer2_binarize #(
  parameter int ACC_W = 16,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic [ACC_W-1:0] data,
  output logic             q
);
  assign q = $signed(data) >= THRESH;
endmodule

// File: rtl/layer2_bin_writer.sv
// layer2_bin_writer: binarizes a layer2 accumulator stream into a 512x1 frame buffer
module layer2_bin_writer #(
  parameter int DEPTH = 512,
  parameter int ADDR_W = 9,
  parameter int ACC_W = 16,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_data,
  input  logic              in_last,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic              dina,
  output logic              buf_valid,
  input  logic              rd_ack,
  output logic [ADDR_W:0]   ones_cnt,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              err
);
  import layer2_bin_writer_pkg::*;
  state_t state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic hs, bit_v, last_slot, frame_end, first;
  layer2_binarize #(.ACC_W(ACC_W), .THRESH(THRESH)) u_bin (.data(in_data), .q(bit_v));
  assign hs = in_valid & in_ready;
  assign last_slot = ptr == ADDR_W'(DEPTH - 1);
  assign frame_end = hs & (in_last | last_slot);
  assign first = state == IDLE;
  // the reader only gets to release the buffer once it has actually seen buf_valid
  always_comb begin
    state_next = state;
    state_next = state == FULL ? ((buf_valid & rd_ack) ? IDLE : FULL)
               : frame_end ? FULL : hs ? FILL : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      in_ready <= 1'b0;
      wea <= 1'b0;
      addra <= '0;
      dina <= 1'b0;
      buf_valid <= 1'b0;
      ones_cnt <= '0;
      wr_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_next;
      in_ready <= state_next != FULL;
      wea <= hs;
      buf_valid <= state == FULL && state_next == FULL;
      if (hs) begin
        addra <= ptr;
        dina <= bit_v;
        wr_cnt <= (first ? '0 : wr_cnt) + (ADDR_W+1)'(1);
        ones_cnt <= (first ? '0 : ones_cnt) + (ADDR_W+1)'(bit_v);
        err <= (first ? 1'b0 : err) | (in_last != last_slot);
        ptr <= frame_end ? ptr : ptr + ADDR_W'(1);
      end
      if (state == FULL && state_next == IDLE) ptr <= '0;
    end
  end
endmodule

// File: tb/tb_layer2_bin_writer.sv
// tb_layer2_bin_writer: directed and random frames checked against a frame-level model
module tb_layer2_bin_writer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, rd_ack = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, wea, dina, buf_valid, err;
  logic [8:0] addra;
  logic [9:0] ones_cnt, wr_cnt;
  int total = 0, bad = 0, wea_seen = 0;
  logic m_rdy = 0, m_full = 0, m_bv = 0, m_wea = 0, m_dina = 0, m_err = 0;
  int idx = 0, m_addr = 0, m_wr = 0, m_ones = 0;

  layer2_bin_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .wea(wea), .addra(addra), .dina(dina), .buf_valid(buf_valid),
    .rd_ack(rd_ack), .ones_cnt(ones_cnt), .wr_cnt(wr_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: drive, advance the frame-level model, compare every output
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic a, input logic r);
    logic hs, b;
    logic signed [15:0] sd;
    in_valid = v; in_data = d; in_last = l; rd_ack = a; rst = r;
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    @(posedge clk); #1;
    sd = d;
    b = sd >= 16'sd0;
    if (r) begin
      m_rdy = 0; m_full = 0; m_bv = 0; idx = 0; m_wea = 0; m_addr = 0;
      m_dina = 0; m_wr = 0; m_ones = 0; m_err = 0;
    end else begin
      hs = v && m_rdy;
      m_wea = hs;
      if (m_full) begin
        if (m_bv && a) begin m_full = 0; m_bv = 0; idx = 0; end
        else m_bv = 1;
      end
      if (hs) begin
        m_addr = idx;
        m_dina = b;
        if (idx == 0) begin m_wr = 0; m_ones = 0; m_err = 0; end
        m_wr++;
        m_ones += int'(b);
        if (l || idx == 511) begin
          m_full = 1;
          if (l != (idx == 511)) m_err = 1;
        end else idx++;
      end
      m_rdy = !m_full;
    end
    if (wea === 1'b1) wea_seen++;
    chk("wea", 32'(wea), 32'(m_wea));
    chk("addra", 32'(addra), 32'(m_addr));
    chk("dina", 32'(dina), 32'(m_dina));
    chk("buf_valid", 32'(buf_valid), 32'(m_bv));
    chk("ones_cnt", 32'(ones_cnt), 32'(m_ones));
    chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic send(input int n, input bit last_end, input bit gaps);
    int k = 0;
    logic v;
    for (int c = 0; c < 20 * n + 10 && k < n; c++) begin
      v = !gaps || $urandom_range(3) != 0;
      if (v && m_rdy) begin
        step(1'b1, 16'($urandom), last_end && k == n - 1, 1'b0, 1'b0);
        k++;
      end else step(v, 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    chk("send_count", 32'(k), 32'(n));
  endtask

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_in_ready", 32'(in_ready), 0);
    step(0, 0, 0, 0, 0);
    // full frame of alternating +5/-5
    for (int i = 0; i < 512; i++) step(1, (i % 2) ? -16'sd5 : 16'sd5, i == 511, 0, 0);
    chk("full_ones", 32'(ones_cnt), 256);
    chk("full_wr", 32'(wr_cnt), 512);
    chk("full_err", 32'(err), 0);
    chk("full_last_addr", 32'(addra), 511);
    chk("full_bv_n1", 32'(buf_valid), 0);
    // backpressure: keep offering samples with no ack
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 0, 0);
    chk("bp_bv", 32'(buf_valid), 1);
    chk("bp_wr", 32'(wr_cnt), 512);
    step(1, 16'h1234, 0, 1, 0);
    chk("ack_no_write", 32'(wea), 0);
    // threshold edges as the next frame, ending early
    step(1, 16'h0000, 0, 0, 0);
    chk("restart_addr", 32'(addra), 0);
    chk("restart_wr", 32'(wr_cnt), 1);
    chk("edge_zero", 32'(dina), 1);
    step(1, 16'hffff, 0, 0, 0);
    chk("edge_m1", 32'(dina), 0);
    step(1, 16'h8000, 0, 0, 0);
    chk("edge_min", 32'(dina), 0);
    step(1, 16'h7fff, 1, 0, 0);
    chk("edge_max", 32'(dina), 1);
    chk("edge_err", 32'(err), 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    // early last on the 100th sample with random gaps
    send(100, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("early_err", 32'(err), 1);
    chk("early_wr", 32'(wr_cnt), 100);
    chk("early_bv", 32'(buf_valid), 1);
    step(0, 0, 0, 1, 0);
    // overrun: first handshake clears err, then no in_last at all
    wea_seen = 0;
    step(1, 16'h0001, 0, 0, 0);
    chk("err_cleared", 32'(err), 0);
    send(511, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 16'($urandom), 0, 0, 0);
    chk("ovr_err", 32'(err), 1);
    chk("ovr_writes", 32'(wea_seen), 512);
    chk("ovr_addr", 32'(addra), 511);
    chk("ovr_wr", 32'(wr_cnt), 512);
    step(0, 0, 0, 1, 0);
    // reset mid-frame right after a handshake
    send(300, 0, 1);
    step(1, 16'h0042, 0, 0, 1);
    chk("rst_wea", 32'(wea), 0);
    chk("rst_wr", 32'(wr_cnt), 0);
    step(0, 0, 0, 0, 0);
    step(1, 16'h0005, 0, 0, 0);
    chk("post_rst_addr", 32'(addra), 0);
    chk("post_rst_wea", 32'(wea), 1);
    send(20, 1, 1);
    step(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
